// File: rtl/uart_mem_master.sv
// uart_mem_master: CPU-side initiator of the UART memory link.
// Serializes one read/write command frame per request and collects the reply.
module uart_mem_master #(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter logic [7:0]  ACK_BYTE       = 8'hAA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        Tx,
  input  logic        Rx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          tx_q, tx_d;
  logic [71:0]   frame_q, frame_d;
  logic [3:0]    bytes_left_q, bytes_left_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic          we_q, we_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_busy_q, rx_busy_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [2:0]    rx_count_q, rx_count_d;
  logic [31:0]   rx_acc_q, rx_acc_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          byte_done;

  assign req_ready  = (state_q == S_IDLE) && RST;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign Tx         = tx_q;

  // Next-state logic: frame serializer, reply receiver, watchdog and response capture.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    frame_d      = frame_q;
    bytes_left_d = bytes_left_q;
    bit_idx_d    = bit_idx_q;
    clk_cnt_d    = clk_cnt_q;
    we_d         = we_q;
    to_cnt_d     = to_cnt_q;
    rx_meta_d    = Rx;
    rx_sync_d    = rx_meta_q;
    rx_busy_d    = rx_busy_q;
    rx_bit_d     = rx_bit_q;
    rx_cnt_d     = rx_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_count_d   = rx_count_q;
    rx_acc_d     = rx_acc_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    byte_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d      = S_SEND;
          we_d         = req_we;
          frame_d      = {req_wdata, req_addr, (req_we ? 8'h02 : 8'h01)};
          bytes_left_d = req_we ? 4'd9 : 4'd5;
          bit_idx_d    = 4'd0;
          clk_cnt_d    = '0;
          tx_d         = 1'b0;
        end
      end

      S_SEND: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 4'd9) begin
            if (bytes_left_q == 4'd1) begin
              state_d    = S_WAIT;
              tx_d       = 1'b1;
              to_cnt_d   = '0;
              rx_busy_d  = 1'b0;
              rx_count_d = 3'd0;
              rx_acc_d   = 32'h0;
            end else begin
              bytes_left_d = bytes_left_q - 1'b1;
              frame_d      = {8'h00, frame_q[71:8]};
              bit_idx_d    = 4'd0;
              tx_d         = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : frame_q[bit_idx_q[2:0]];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!rx_busy_q) begin
          if (!rx_sync_q) begin
            rx_busy_d = 1'b1;
            rx_bit_d  = 4'd0;
            rx_cnt_d  = CW'(1);
          end
        end else if (rx_bit_q == 4'd0) begin
          if (rx_cnt_q == BIT_HALF) begin
            if (rx_sync_q) begin
              rx_busy_d = 1'b0;
            end else begin
              rx_bit_d = 4'd1;
              rx_cnt_d = CW'(1);
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end else if (rx_cnt_q == BIT_FULL) begin
          rx_cnt_d = CW'(1);
          if (rx_bit_q == 4'd9) begin
            rx_busy_d = 1'b0;
            byte_done = rx_sync_q;
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end

        if (byte_done) begin
          if (we_q) begin
            state_d    = S_DONE;
            resp_err_d = (rx_shift_q != ACK_BYTE);
          end else begin
            rx_acc_d[{rx_count_q[1:0], 3'b000} +: 8] = rx_shift_q;
            rx_count_d = rx_count_q + 1'b1;
            if (rx_count_q == 3'd3) begin
              state_d    = S_DONE;
              resp_err_d = 1'b0;
            end
          end
        end

        if ((state_d == S_WAIT) && (to_cnt_q == TO_LAST)) begin
          state_d    = S_DONE;
          resp_err_d = 1'b1;
        end

        if (state_d == S_DONE) begin
          resp_valid_d = 1'b1;
          if (!we_q) begin
            resp_rdata_d = rx_acc_d;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register: everything returns to idle with the line high on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      tx_q         <= 1'b1;
      frame_q      <= '0;
      bytes_left_q <= '0;
      bit_idx_q    <= '0;
      clk_cnt_q    <= '0;
      we_q         <= 1'b0;
      to_cnt_q     <= '0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_busy_q    <= 1'b0;
      rx_bit_q     <= '0;
      rx_cnt_q     <= '0;
      rx_shift_q   <= '0;
      rx_count_q   <= '0;
      rx_acc_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      frame_q      <= frame_d;
      bytes_left_q <= bytes_left_d;
      bit_idx_q    <= bit_idx_d;
      clk_cnt_q    <= clk_cnt_d;
      we_q         <= we_d;
      to_cnt_q     <= to_cnt_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_busy_q    <= rx_busy_d;
      rx_bit_q     <= rx_bit_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_count_q   <= rx_count_d;
      rx_acc_q     <= rx_acc_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_master.sv
// tb_uart_mem_master: directed and randomized checks of the UART memory master
// against a transaction-level model of the link.
`timescale 1ns/1ps
module tb_uart_mem_master;

  localparam int CPB  = 4;
  localparam int TO   = 200;
  localparam logic [7:0] ACK = 8'hAA;
  localparam int HALF = 5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        Rx = 1'b1;
  logic        req_ready, resp_valid, resp_err, Tx;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level model state
  bit          tx_active = 1'b0;
  int          acc_cyc = 0;
  bit          tx_bits[$];
  bit          pending = 1'b0;
  bit          exp_we = 1'b0;
  int          wait_start = 0;
  logic [7:0]  rx_sent[$];
  logic [7:0]  tx_seen[$];
  logic [7:0]  tx_cur = 8'h00;
  int          acc_cnt = 0;
  int          resp_cnt = 0;
  int          last_acc_obs_cyc = 0;
  int          last_resp_cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  uart_mem_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO), .ACK_BYTE(ACK)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Tx(Tx), .Rx(Rx)
  );

  always #HALF CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model: Tx bit stream, req_ready, responses, acceptances.
  int          m_idx, m_off, m_n;
  bit          m_exp_tx, m_complete, m_err;
  logic [31:0] m_rdata;
  logic [7:0]  m_frame[9];
  always @(negedge CLK) begin
    m_exp_tx = 1'b1;
    if (tx_active && cyc >= acc_cyc) begin
      m_idx = (cyc - acc_cyc) / CPB;
      m_off = (cyc - acc_cyc) % CPB;
      if (m_idx < tx_bits.size()) begin
        m_exp_tx = tx_bits[m_idx];
        if (m_off == CPB / 2 && (m_idx % 10) >= 1 && (m_idx % 10) <= 8) begin
          tx_cur = {Tx, tx_cur[7:1]};
          if ((m_idx % 10) == 8) tx_seen.push_back(tx_cur);
        end
      end
    end
    checkOutput("tx_line", 32'(Tx), 32'(m_exp_tx));
    checkOutput("req_ready", 32'(req_ready), 32'(RST && !pending));

    if (resp_valid) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      last_rdata = resp_rdata;
      last_err = resp_err;
      checkOutput("resp_expected", 32'(pending), 32'd1);
      if (pending) begin
        m_n = rx_sent.size();
        if (exp_we) begin
          m_complete = (m_n >= 1);
          m_err = !m_complete || (rx_sent[0] != ACK);
        end else begin
          m_complete = (m_n >= 4);
          m_err = !m_complete;
          m_rdata = 32'h0;
          for (int i = 0; i < 4 && i < m_n; i++) m_rdata[8*i +: 8] = rx_sent[i];
          checkOutput("resp_rdata", resp_rdata, m_rdata);
        end
        checkOutput("resp_err", 32'(resp_err), 32'(m_err));
        if (!m_complete) checkOutput("timeout_cycle", 32'(cyc), 32'(wait_start + TO));
        else checkOutput("completion_before_timeout", 32'(cyc < wait_start + TO), 32'd1);
        pending = 1'b0;
      end
    end

    if (RST && req_valid && req_ready) begin
      acc_cnt++;
      last_acc_obs_cyc = cyc;
      pending = 1'b1;
      exp_we = req_we;
      acc_cyc = cyc + 1;
      tx_active = 1'b1;
      m_frame[0] = req_we ? 8'h02 : 8'h01;
      for (int i = 0; i < 4; i++) m_frame[1+i] = req_addr[8*i +: 8];
      for (int i = 0; i < 4; i++) m_frame[5+i] = req_wdata[8*i +: 8];
      m_n = req_we ? 9 : 5;
      tx_bits.delete();
      for (int b = 0; b < m_n; b++) begin
        tx_bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) tx_bits.push_back(m_frame[b][k]);
        tx_bits.push_back(1'b1);
      end
      wait_start = acc_cyc + m_n * 10 * CPB;
      rx_sent.delete();
      tx_seen.delete();
    end
  end

  task automatic waitAccept();
    int start = acc_cnt;
    int n = 0;
    while (acc_cnt == start && n < 3000) begin
      @(negedge CLK); #1;
      n++;
    end
    checkOutput("accept_seen", 32'(acc_cnt != start), 32'd1);
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge CLK); #1;
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    waitAccept();
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitTxDone();
    int n = 0;
    while (cyc < wait_start + 1 && n < 1000) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("tx_done_seen", 32'(cyc >= wait_start + 1), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic sendRxByte(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    rx_sent.push_back(b);
    for (int k = 0; k < 10; k++) begin
      Rx = bits[k];
      repeat (CPB) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic waitResp();
    int start = resp_cnt;
    int n = 0;
    while (resp_cnt == start && n < 800) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("resp_seen", 32'(resp_cnt != start), 32'd1);
  endtask

  task automatic checkTxBytes(input string name, input logic [71:0] exp, input int n);
    checkOutput({name, "_count"}, 32'(tx_seen.size()), 32'(n));
    for (int i = 0; i < n && i < tx_seen.size(); i++)
      checkOutput(name, 32'(tx_seen[i]), 32'(exp[8*i +: 8]));
  endtask

  initial begin
    #(HALF * 2 * 60000);
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int saved;
    bit we;
    int mode;
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_tx", 32'(Tx), 32'd1);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_err", 32'(resp_err), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'h0);
    @(posedge CLK); #2 RST = 1'b1;
    @(negedge CLK); #1;
    checkOutput("ready_after_release", 32'(req_ready), 32'd1);

    $display("[TB] directed read");
    applyStimulus(1'b0, 32'h0000_1234, 32'h5555_5555);
    waitTxDone();
    checkTxBytes("rd_tx_byte", 72'h00_0000_0000_0012_3401, 5);
    idle(3);
    sendRxByte(8'hEF); sendRxByte(8'hBE); sendRxByte(8'hAD); sendRxByte(8'hDE);
    waitResp();
    checkOutput("rd_rdata_literal", last_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_err_literal", 32'(last_err), 32'd0);

    $display("[TB] directed writes");
    applyStimulus(1'b1, 32'h0000_0010, 32'hCAFE_BABE);
    waitTxDone();
    checkTxBytes("wr_tx_byte", 72'hCA_FEBA_BE00_0000_1002, 9);
    idle(2);
    sendRxByte(8'hAA);
    waitResp();
    checkOutput("wr_ack_err_literal", 32'(last_err), 32'd0);
    idle(2);
    applyStimulus(1'b1, 32'h0000_0010, 32'hCAFE_BABE);
    waitTxDone();
    idle(2);
    sendRxByte(8'h55);
    waitResp();
    checkOutput("wr_nak_err_literal", 32'(last_err), 32'd1);

    $display("[TB] timeouts");
    idle(2);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0);
    waitTxDone();
    waitResp();
    checkOutput("to_latency_literal", 32'(last_resp_cyc - acc_cyc), 32'd400);
    checkOutput("to_rdata_literal", last_rdata, 32'h0);
    checkOutput("to_err_literal", 32'(last_err), 32'd1);
    idle(2);
    applyStimulus(1'b0, 32'h0000_0044, 32'h0);
    waitTxDone();
    idle(4);
    sendRxByte(8'h11); sendRxByte(8'h22);
    waitResp();
    checkOutput("partial_rdata_literal", last_rdata, 32'h0000_2211);
    checkOutput("partial_err_literal", 32'(last_err), 32'd1);

    $display("[TB] Rx glitch");
    idle(2);
    applyStimulus(1'b0, 32'h0000_0080, 32'h0);
    waitTxDone();
    idle(3);
    Rx = 1'b0;
    idle(1);
    Rx = 1'b1;
    idle(6);
    sendRxByte(8'h01); sendRxByte(8'h02); sendRxByte(8'h03); sendRxByte(8'h04);
    waitResp();
    checkOutput("glitch_rdata_literal", last_rdata, 32'h0403_0201);
    checkOutput("glitch_err_literal", 32'(last_err), 32'd0);

    $display("[TB] request held while busy");
    idle(2);
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100; req_wdata = 32'h0;
    waitAccept();
    waitTxDone();
    idle(2);
    sendRxByte(8'h10); sendRxByte(8'h20); sendRxByte(8'h30); sendRxByte(8'h40);
    waitResp();
    waitAccept();
    checkOutput("held_accept_cycle", 32'(last_acc_obs_cyc), 32'(last_resp_cyc + 1));
    @(posedge CLK); #1;
    req_valid = 1'b0;
    waitTxDone();
    idle(2);
    sendRxByte(8'h99); sendRxByte(8'h88); sendRxByte(8'h77); sendRxByte(8'h66);
    waitResp();
    checkOutput("held_second_rdata", last_rdata, 32'h6677_8899);

    $display("[TB] reset mid-frame");
    idle(2);
    applyStimulus(1'b0, 32'h0000_1234, 32'h0);
    while (cyc < acc_cyc + 85) begin @(posedge CLK); #1; end
    checkOutput("tx_before_reset", 32'(Tx), 32'd0);
    #1;
    RST = 1'b0;
    pending = 1'b0;
    tx_active = 1'b0;
    saved = resp_cnt;
    #1;
    checkOutput("tx_in_reset", 32'(Tx), 32'd1);
    checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge CLK); @(posedge CLK); #2 RST = 1'b1;
    @(negedge CLK); #1;
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
    idle(20);
    checkOutput("no_resp_after_reset", 32'(resp_cnt), 32'(saved));
    applyStimulus(1'b0, 32'h0000_2000, 32'h0);
    waitTxDone();
    idle(2);
    sendRxByte(8'h5A); sendRxByte(8'hA5); sendRxByte(8'h3C); sendRxByte(8'hC3);
    waitResp();
    checkOutput("post_reset_rdata", last_rdata, 32'hC33C_A55A);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 12; t++) begin
      idle(2);
      we = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      applyStimulus(we, $urandom, $urandom);
      waitTxDone();
      idle($urandom_range(1, 6));
      if (we) begin
        if (mode == 1) sendRxByte(8'($urandom));
        else if (mode >= 2) sendRxByte(ACK);
      end else begin
        if (mode == 0) begin
          for (int b = $urandom_range(0, 3); b > 0; b--) sendRxByte(8'($urandom));
        end else begin
          for (int b = 0; b < 4; b++) sendRxByte(8'($urandom));
        end
      end
      waitResp();
    end

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
